nano_imem: RTL and testbench
============================

# nano_imem

Instruction memory and program loader for the nano_riscv core. Serves the word at the core's fetch address every cycle, and loads a program from an 8-bit byte stream while holding the core in reset. Sits between the external host/UART byte source and the core's instruction fetch port. It is the responder end of the core's pc → instruction interface.

## Interface

Parameters:
- `ADDR_W`, default 10: log2 of memory depth in 32-bit words (default 1024 words).
- `RESET_INST`, default 32'h00000013: instruction driven on `o_inst` while not in RUN. The default is NOP (addi x0,x0,0).

Ports:
- `i_clk`  in  1: clock. One clock domain; all registers are on the rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_pc`  in  32: fetch address from the core. Word index; bits [ADDR_W-1:0] are used and upper bits are ignored (aliasing).
- `o_inst`  out  32: instruction for `i_pc`.
- `i_ld_start`  in  1: single-cycle pulse that (re)starts a program load.
- `i_ld_valid`  in  1: loader byte valid.
- `i_ld_data`  in  8: loader byte.
- `o_ld_ready`  out  1: loader can accept a byte. A byte transfers when `i_ld_valid && o_ld_ready`.
- `o_core_rst`  out  1: reset to the core, registered. High except in RUN.
- `o_loaded`  out  16: number of words written by the current/last load.

## Operation

- States: HDR0, HDR1, DATA, RUN. `i_rst` forces HDR0.
- HDR0: accepts length byte 0 (N[7:0]) → HDR1.
- HDR1: accepts length byte 1 (N[15:8]).
  - If N==0 → RUN.
  - Otherwise → DATA. Word pointer and byte index are cleared.
- DATA: bytes are little-endian; the first byte is inst[7:0].
  - Bytes 0..2 are held in a 24-bit buffer.
  - On byte 3, mem[ptr] is written with {b3,b2,b1,b0}; ptr increments and `o_loaded` increments.
  - When `o_loaded` reaches N → RUN.
- Pointer wraps modulo 2^ADDR_W. When N > depth, later words overwrite earlier ones and `o_loaded` still counts to N.
- RUN: `o_ld_ready`=0. Stream bytes are ignored.
- `i_ld_start`, in any state:
  - Next state HDR0, `o_loaded` cleared, partial word discarded.
  - Memory contents are kept.
  - In RUN it reasserts `o_core_rst` from the next edge.
- `o_ld_ready` = (state != RUN) && !`i_ld_start`, combinational. A byte is therefore never accepted on a start cycle.
- `o_inst` = mem[`i_pc`[ADDR_W-1:0]] in RUN, else `RESET_INST`. The read is combinational (asynchronous), as the single-cycle core requires.
- Memory array is not cleared by `i_rst`. It is undefined at power-up and preserved across `i_rst`.

## Timing

- Reset values:
  - state = HDR0
  - `o_core_rst` = 1
  - `o_loaded` = 0
  - `o_ld_ready` = 1 (unless `i_ld_start`)
  - `o_inst` = `RESET_INST`
  - ptr = 0, byte index = 0
- One byte per cycle maximum. Full throughput is valid held high for 2+4N cycles.
- On the edge that accepts the final byte of word N:
  - The memory write commits.
  - state becomes RUN.
  - `o_core_rst` falls.
- Consequently, in the first cycle with `o_core_rst`=0, `o_inst` already returns the final word if addressed. Load-to-run latency is 0 cycles after the last accepted byte edge.
- N==0: `o_core_rst` falls on the edge accepting length byte 1.
- `o_core_rst` rises on the edge after an `i_ld_start` cycle. It is registered, glitch-free.
- `i_rst` asserted mid-load: immediate return to HDR0 with the reset values above. Words written before reset remain in memory.
- Stalls (`i_ld_valid`=0) in any load state hold all state, buffer and counters.
- `o_loaded` width is 16 and covers the full N range. ptr is ADDR_W bits.

## Test plan

- Reset, then stream 02 00 13 05 10 00 93 05 20 00 →
  - mem[0]=32'h00100513, mem[1]=32'h00200593
  - `o_core_rst` falls on the 10th accepting edge
  - `o_loaded`=2
  - `i_pc`=1 gives 32'h00200593; `i_pc`=32'h401 (ADDR_W=10) gives the same.
- During load, `i_pc`=0 → `o_inst`=32'h00000013 and `o_core_rst`=1 throughout.
- Stream 00 00 → RUN after 2 bytes. `o_loaded`=0. Memory is unchanged from the previous load.
- Load 1 word with `i_ld_valid` toggling every other cycle → same memory result, and `o_core_rst` falls on the edge of the last accepted byte only.
- In RUN, pulse `i_ld_start` with `i_ld_valid`=1 in the same cycle:
  - `o_ld_ready`=0 that cycle and the byte is not taken.
  - `o_core_rst`=1 next cycle; `o_loaded`=0.
  - A new 1-word load of 32'hDEADBEEF writes mem[0].
- Assert `i_rst` after 2 data bytes of word 1 (word 0 complete) → all reset values restored and mem[0] retained. A fresh header-plus-1-word load then writes mem[0] again.

Source files
------------

// File: rtl/nano_imem_if.sv
// Core fetch port plus loader byte stream between nano_imem and its host/core.
interface nano_imem_if;
    logic [31:0] i_pc;
    logic [31:0] o_inst;
    logic        i_ld_start;
    logic        i_ld_valid;
    logic [7:0]  i_ld_data;
    logic        o_ld_ready;
    logic        o_core_rst;
    logic [15:0] o_loaded;

    modport master (
        output i_pc, i_ld_start, i_ld_valid, i_ld_data,
        input  o_inst, o_ld_ready, o_core_rst, o_loaded
    );

    modport slave (
        input  i_pc, i_ld_start, i_ld_valid, i_ld_data,
        output o_inst, o_ld_ready, o_core_rst, o_loaded
    );
endinterface

// File: rtl/nano_imem.sv
// Instruction memory with asynchronous read and a byte-stream program loader
// that holds the core in reset until the announced word count has been written.
module nano_imem #(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input logic        i_clk,
    input logic        i_rst,
    nano_imem_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {HDR0, HDR1, DATA, RUN} state_t;

    state_t            state, state_n;
    logic [15:0]       len_q;
    logic [15:0]       loaded_q;
    logic [ADDR_W-1:0] ptr;
    logic [1:0]        bidx;
    logic [23:0]       byte_buf;
    logic              core_rst_q;
    logic              ld_ready;
    logic              accept;
    logic              word_we;
    logic [31:0]       mem [DEPTH];
    logic              unused_pc_hi;

    assign ld_ready = (state != RUN) && !bus.i_ld_start;
    assign accept   = bus.i_ld_valid && ld_ready;
    assign word_we  = accept && (state == DATA) && (bidx == 2'd3);

    always_comb begin
        state_n = state;
        if (bus.i_ld_start) begin
            state_n = HDR0;
        end else if (accept) begin
            unique case (state)
                HDR0: state_n = HDR1;
                HDR1: state_n = ({bus.i_ld_data, len_q[7:0]} == 16'd0) ? RUN : DATA;
                DATA: if (word_we && (loaded_q + 16'd1 == len_q)) state_n = RUN;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= HDR0;
            core_rst_q <= 1'b1;
        end else begin
            state      <= state_n;
            // Registered from next state so the core leaves reset on the same
            // edge that commits the last word (or accepts N==0).
            core_rst_q <= (state_n != RUN);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            len_q    <= '0;
            loaded_q <= '0;
            ptr      <= '0;
            bidx     <= '0;
            byte_buf <= '0;
        end else if (bus.i_ld_start) begin
            loaded_q <= '0;
            bidx     <= '0;
        end else if (accept) begin
            unique case (state)
                HDR0: len_q[7:0] <= bus.i_ld_data;
                HDR1: begin
                    len_q[15:8] <= bus.i_ld_data;
                    ptr         <= '0;
                    bidx        <= '0;
                end
                DATA: begin
                    unique case (bidx)
                        2'd0: byte_buf[7:0]   <= bus.i_ld_data;
                        2'd1: byte_buf[15:8]  <= bus.i_ld_data;
                        2'd2: byte_buf[23:16] <= bus.i_ld_data;
                        default: begin
                            ptr      <= ptr + ADDR_W'(1);
                            loaded_q <= loaded_q + 16'd1;
                        end
                    endcase
                    bidx <= bidx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so programs survive i_rst.
    always_ff @(posedge i_clk) begin
        if (word_we) mem[ptr] <= {bus.i_ld_data, byte_buf};
    end

    assign unused_pc_hi   = ^bus.i_pc[31:ADDR_W];
    assign bus.o_inst     = (state == RUN) ? mem[bus.i_pc[ADDR_W-1:0]] : RESET_INST;
    assign bus.o_ld_ready = ld_ready;
    assign bus.o_core_rst = core_rst_q;
    assign bus.o_loaded   = loaded_q;

endmodule

// File: tb/tb_nano_imem.sv
// Directed vector bench for nano_imem: loads, N==0, stalls, restart and mid-load reset.
module tb_nano_imem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    nano_imem_if bus ();

    nano_imem #(.ADDR_W(10), .RESET_INST(NOP)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vl;
        logic [7:0]  d;
        logic [31:0] pc;
        logic        rdy;
        logic        crst;
        logic [15:0] ld;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic vl, logic [7:0] d, logic [31:0] pc,
                                logic rdy, logic crst, logic [15:0] ld, logic [31:0] inst);
        vec_t v;
        v.st = st; v.vl = vl; v.d = d; v.pc = pc;
        v.rdy = rdy; v.crst = crst; v.ld = ld; v.inst = inst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change at posedge+1; ready is checked before the edge, registered
    // outputs and the read port just after it.
    task automatic apply(input string name, input vec_t v);
        bus.i_ld_start = v.st;
        bus.i_ld_valid = v.vl;
        bus.i_ld_data  = v.d;
        bus.i_pc       = v.pc;
        #1;
        chk({name, ".ready"}, {31'd0, bus.o_ld_ready}, {31'd0, v.rdy});
        @(posedge clk);
        #1;
        chk({name, ".core_rst"}, {31'd0, bus.o_core_rst}, {31'd0, v.crst});
        chk({name, ".loaded"}, {16'd0, bus.o_loaded}, {16'd0, v.ld});
        chk({name, ".inst"}, bus.o_inst, v.inst);
    endtask

    initial begin
        // two-word load, checks in RUN, pc aliasing
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h13, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h05, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h10, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 1, NOP));
        vecs.push_back(mk(0, 1, 8'h93, 0, 1, 1, 1, NOP));
        vecs.push_back(mk(0, 1, 8'h05, 0, 1, 1, 1, NOP));
        vecs.push_back(mk(0, 1, 8'h20, 0, 1, 1, 1, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 2, 32'h0010_0513));
        vecs.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 2, 32'h0020_0593));
        vecs.push_back(mk(0, 0, 8'h00, 32'h401, 0, 0, 2, 32'h0020_0593));
        // N==0 reload keeps memory
        vecs.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0, 32'h0020_0593));
        // one word with valid toggling
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 0, 8'h5A, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 0, 8'hA5, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h13, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 0, 8'h77, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h05, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 0, 8'h66, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h10, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 0, 8'h55, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 1, 32'h0010_0513));
        // start with valid in RUN, then DEADBEEF into mem[0]
        vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'hEF, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'hBE, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'hAD, 0, 1, 1, 0, NOP));
        vecs.push_back(mk(0, 1, 8'hDE, 0, 1, 0, 1, 32'hDEAD_BEEF));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1, 32'h0020_0593));

        rst            = 1'b1;
        bus.i_ld_start = 1'b0;
        bus.i_ld_valid = 1'b0;
        bus.i_ld_data  = 8'h00;
        bus.i_pc       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.core_rst", {31'd0, bus.o_core_rst}, 32'd1);
        chk("reset.loaded", {16'd0, bus.o_loaded}, 32'd0);
        chk("reset.ready", {31'd0, bus.o_ld_ready}, 32'd1);
        chk("reset.inst", bus.o_inst, NOP);
        bus.i_ld_start = 1'b1;
        #1;
        chk("reset.ready_start", {31'd0, bus.o_ld_ready}, 32'd0);
        bus.i_ld_start = 1'b0;
        rst = 1'b0;

        for (int unsigned i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // mid-load reset: word 0 = 44332211 complete, two bytes of word 1 buffered
        apply("mr_start", mk(1, 0, 8'h00, 0, 0, 1, 0, NOP));
        apply("mr_n0",    mk(0, 1, 8'h02, 0, 1, 1, 0, NOP));
        apply("mr_n1",    mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        apply("mr_b0",    mk(0, 1, 8'h11, 0, 1, 1, 0, NOP));
        apply("mr_b1",    mk(0, 1, 8'h22, 0, 1, 1, 0, NOP));
        apply("mr_b2",    mk(0, 1, 8'h33, 0, 1, 1, 0, NOP));
        apply("mr_b3",    mk(0, 1, 8'h44, 0, 1, 1, 1, NOP));
        apply("mr_b4",    mk(0, 1, 8'h55, 0, 1, 1, 1, NOP));
        apply("mr_b5",    mk(0, 1, 8'h66, 0, 1, 1, 1, NOP));
        bus.i_ld_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr.core_rst", {31'd0, bus.o_core_rst}, 32'd1);
        chk("mr.loaded", {16'd0, bus.o_loaded}, 32'd0);
        chk("mr.ready", {31'd0, bus.o_ld_ready}, 32'd1);
        chk("mr.inst", bus.o_inst, NOP);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // N==0 exposes memory: mem[0] must be retained
        apply("mr_z0",  mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        apply("mr_z1",  mk(0, 1, 8'h00, 0, 1, 0, 0, 32'h4433_2211));
        apply("fr_st",  mk(1, 0, 8'h00, 0, 0, 1, 0, NOP));
        apply("fr_n0",  mk(0, 1, 8'h01, 0, 1, 1, 0, NOP));
        apply("fr_n1",  mk(0, 1, 8'h00, 0, 1, 1, 0, NOP));
        apply("fr_b0",  mk(0, 1, 8'h78, 0, 1, 1, 0, NOP));
        apply("fr_b1",  mk(0, 1, 8'h56, 0, 1, 1, 0, NOP));
        apply("fr_b2",  mk(0, 1, 8'h34, 0, 1, 1, 0, NOP));
        apply("fr_b3",  mk(0, 1, 8'h12, 0, 1, 0, 1, 32'h1234_5678));
        apply("fr_pc1", mk(0, 0, 8'h00, 1, 0, 0, 1, 32'h0020_0593));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
